pdp8_opr_sequencer: RTL and testbench

- Multi-cycle sequencer for PDP-8 operate (OPR, opcode 7) microinstructions.
- Takes a latched OPR word from the main controller and issues one datapath control step per cycle, in architectural order, against the AC/link datapath.
- Group 1 covers CLA/CLL, CMA/CML, IAC, and single or double rotate.
- Group 2 covers the skip test, CLA and HLT.
- Reports skip, halt and completion back to the main controller.

---
 rtl/pdp8_opr_sequencer_if.sv | 38 +++
 rtl/pdp8_opr_sequencer.sv | 161 ++++++++++++++++
 tb/tb_pdp8_opr_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pdp8_opr_sequencer_if.sv
// Handshake and datapath bundle between the main controller/datapath (master)
// and the PDP-8 OPR microinstruction sequencer (slave).
interface pdp8_opr_sequencer_if;
  // Controller/datapath -> sequencer
  logic        start;
  logic [11:0] instruction;
  logic        cyout;
  logic        accminus;
  logic        acczero;
  logic        resume;
  // Sequencer -> controller/datapath
  logic        busy;
  logic        done;
  logic        illegal;
  logic        clearacc;
  logic        clearcy;
  logic        compacc;
  logic        compcy;
  logic        incacc;
  logic        RL;
  logic        RR;
  logic        accwrite;
  logic        cywrite;
  logic        pcskip;
  logic        halt;

  modport master (
    output start, instruction, cyout, accminus, acczero, resume,
    input  busy, done, illegal, clearacc, clearcy, compacc, compcy, incacc,
           RL, RR, accwrite, cywrite, pcskip, halt
  );

  modport slave (
    input  start, instruction, cyout, accminus, acczero, resume,
    output busy, done, illegal, clearacc, clearcy, compacc, compcy, incacc,
           RL, RR, accwrite, cywrite, pcskip, halt
  );
endinterface

// File: rtl/pdp8_opr_sequencer.sv
// PDP-8 operate (OPR) microinstruction sequencer. Latches an OPR word and
// issues one datapath step per cycle in architectural order, skipping steps
// whose micro-op set is empty. Reports skip, halt, illegal and completion.
module pdp8_opr_sequencer #(
  parameter int IW     = 12,
  parameter bit HLT_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  pdp8_opr_sequencer_if.slave   bus
);

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] S_CLR  = 4'd1;
  localparam logic [3:0] S_CMP  = 4'd2;
  localparam logic [3:0] S_IAC  = 4'd3;
  localparam logic [3:0] S_ROT1 = 4'd4;
  localparam logic [3:0] S_ROT2 = 4'd5;
  localparam logic [3:0] S_SKIP = 4'd6;
  localparam logic [3:0] S_CLA2 = 4'd7;
  localparam logic [3:0] DONE   = 4'd8;

  logic [3:0]    state_q, state_d;
  logic [IW-1:0] word_q, word_d;
  logic          halt_q, halt_d;

  function automatic logic is_g1(input logic [11:0] w);
    return (w[11:9] == 3'b111) && !w[8];
  endfunction

  function automatic logic is_g2(input logic [11:0] w);
    return (w[11:9] == 3'b111) && w[8] && !w[0];
  endfunction

  // A rotate happens only when exactly one direction bit is set.
  function automatic logic rot_active(input logic [11:0] w);
    return is_g1(w) && (w[3] ^ w[2]);
  endfunction

  function automatic logic step_active(input logic [3:0] s, input logic [11:0] w);
    logic act;
    act = 1'b0;
    case (s)
      S_CLR:   act = is_g1(w) && (w[7] || w[6]);
      S_CMP:   act = is_g1(w) && (w[5] || w[4]);
      S_IAC:   act = is_g1(w) && w[0];
      S_ROT1:  act = rot_active(w);
      S_ROT2:  act = rot_active(w) && w[1];
      S_SKIP:  act = is_g2(w);
      S_CLA2:  act = is_g2(w) && w[7];
      default: act = 1'b0;
    endcase
    return act;
  endfunction

  // First active step strictly after cur; DONE when none remain. Illegal
  // words have no active steps, so they fall straight through to DONE.
  function automatic logic [3:0] next_step(input logic [3:0] cur, input logic [11:0] w);
    logic [3:0] nxt;
    nxt = DONE;
    for (int s = 7; s >= 1; s--) begin
      if (s[3:0] > cur && step_active(s[3:0], w)) nxt = s[3:0];
    end
    return nxt;
  endfunction

  // Next-state, word latch and sticky halt.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    word_d  = word_q;
    halt_d  = halt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          word_d  = bus.instruction;
          state_d = next_step(IDLE, bus.instruction);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = next_step(state_q, word_q);
    endcase
    // Set has priority over resume when both happen in the same cycle.
    if (HLT_EN && state_q != IDLE && state_d == DONE && is_g2(word_q) && word_q[1])
      halt_d = 1'b1;
    else if (bus.resume)
      halt_d = 1'b0;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      halt_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q <= state_d;
      word_q  <= word_d;
      halt_q  <= halt_d;
    end
  end

  // Moore strobe decode from state and latched word; pcskip also looks at flags.
  always_comb begin
    bus.busy     = (state_q != IDLE);
    bus.done     = 1'b0;
    bus.illegal  = 1'b0;
    bus.clearacc = 1'b0;
    bus.clearcy  = 1'b0;
    bus.compacc  = 1'b0;
    bus.compcy   = 1'b0;
    bus.incacc   = 1'b0;
    bus.RL       = 1'b0;
    bus.RR       = 1'b0;
    bus.accwrite = 1'b0;
    bus.cywrite  = 1'b0;
    bus.pcskip   = 1'b0;
    bus.halt     = halt_q;
    case (state_q)
      S_CLR: begin
        bus.clearacc = word_q[7];
        bus.clearcy  = word_q[6];
        bus.accwrite = word_q[7];
        bus.cywrite  = word_q[6];
      end
      S_CMP: begin
        bus.compacc  = word_q[5];
        bus.compcy   = word_q[4];
        bus.accwrite = word_q[5];
        bus.cywrite  = word_q[4];
      end
      S_IAC: begin
        bus.incacc   = 1'b1;
        bus.accwrite = 1'b1;
        bus.cywrite  = 1'b1;
      end
      S_ROT1, S_ROT2: begin
        bus.RR       = word_q[3];
        bus.RL       = word_q[2];
        bus.accwrite = 1'b1;
        bus.cywrite  = 1'b1;
      end
      S_SKIP: begin
        bus.pcskip = word_q[3] ^ ((word_q[6] & bus.accminus) |
                                  (word_q[5] & bus.acczero)  |
                                  (word_q[4] & bus.cyout));
      end
      S_CLA2: begin
        bus.clearacc = 1'b1;
        bus.accwrite = 1'b1;
      end
      DONE: begin
        bus.done    = 1'b1;
        bus.illegal = !(is_g1(word_q) || is_g2(word_q));
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pdp8_opr_sequencer.sv
// Self-checking bench for pdp8_opr_sequencer: directed cases plus random OPR
// words checked against a per-cycle expected step list built from the
// instruction-set rules. A second instance with HLT_EN=0 shares stimulus.
module tb_pdp8_opr_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pdp8_opr_sequencer_if if0 ();
  pdp8_opr_sequencer_if if1 ();

  pdp8_opr_sequencer #(.IW(12), .HLT_EN(1'b1)) dut    (.clk(clk), .rst(rst), .bus(if0.slave));
  pdp8_opr_sequencer #(.IW(12), .HLT_EN(1'b0)) dut_nh (.clk(clk), .rst(rst), .bus(if1.slave));

  assign if1.start       = if0.start;
  assign if1.instruction = if0.instruction;
  assign if1.cyout       = if0.cyout;
  assign if1.accminus    = if0.accminus;
  assign if1.acczero     = if0.acczero;
  assign if1.resume      = if0.resume;

  // Observed strobe vector: {clearacc, clearcy, compacc, compcy, incacc, RL, RR, accwrite, cywrite, pcskip}
  typedef logic [9:0] strobes_t;
  localparam strobes_t ST_CLA = 10'b1000000_10_0;
  localparam strobes_t ST_CLL = 10'b0100000_01_0;
  localparam strobes_t ST_CMA = 10'b0010000_10_0;
  localparam strobes_t ST_CML = 10'b0001000_01_0;
  localparam strobes_t ST_IAC = 10'b0000100_11_0;
  localparam strobes_t ST_RAL = 10'b0000010_11_0;
  localparam strobes_t ST_RAR = 10'b0000001_11_0;
  localparam strobes_t ST_SKP = 10'b0000000_00_1;

  int n_checks = 0;
  int n_pass   = 0;
  logic halt_exp = 1'b0;
  strobes_t exp_q[$];

  function automatic strobes_t observed();
    return {if0.clearacc, if0.clearcy, if0.compacc, if0.compcy, if0.incacc,
            if0.RL, if0.RR, if0.accwrite, if0.cywrite, if0.pcskip};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: list of strobe vectors, one per active cycle, from the OPR rules.
  function automatic logic model(input logic [11:0] w, input logic cy, input logic am,
                                 input logic az, output logic hlt);
    logic legal1, legal2, cnd;
    strobes_t v;
    exp_q.delete();
    hlt    = 1'b0;
    legal1 = (w[11:9] == 3'b111) && (w[8] == 1'b0);
    legal2 = (w[11:9] == 3'b111) && (w[8] == 1'b1) && (w[0] == 1'b0);
    if (legal1) begin
      v = (w[7] ? ST_CLA : '0) | (w[6] ? ST_CLL : '0);
      if (v != 0) exp_q.push_back(v);
      v = (w[5] ? ST_CMA : '0) | (w[4] ? ST_CML : '0);
      if (v != 0) exp_q.push_back(v);
      if (w[0]) exp_q.push_back(ST_IAC);
      if (w[3] != w[2]) begin
        v = w[3] ? ST_RAR : ST_RAL;
        exp_q.push_back(v);
        if (w[1]) exp_q.push_back(v);
      end
    end
    if (legal2) begin
      cnd = (w[6] && am) || (w[5] && az) || (w[4] && cy);
      exp_q.push_back((w[3] ? !cnd : cnd) ? ST_SKP : '0);
      if (w[7]) exp_q.push_back(ST_CLA);
      hlt = w[1];
    end
    return !(legal1 || legal2);
  endfunction

  // Run one instruction and check every cycle until return to IDLE.
  task automatic do_op(input string name, input logic [11:0] w, input logic cy, input logic am,
                       input logic az, input logic hold_start, input logic hold_resume);
    logic ill, hlt;
    strobes_t e;
    ill = model(w, cy, am, az, hlt);
    @(negedge clk);
    if0.instruction = w;
    if0.start       = 1'b1;
    if0.cyout       = cy;
    if0.accminus    = am;
    if0.acczero     = az;
    if0.resume      = hold_resume;
    @(posedge clk); #1;
    if (!hold_start) if0.start = 1'b0;
    if0.instruction = 12'(~w);
    foreach (exp_q[k]) begin
      e = exp_q[k];
      check({name, " strobes"}, 32'(observed()), 32'(e));
      check({name, " busy"},    32'(if0.busy), 32'd1);
      check({name, " done"},    32'(if0.done), 32'd0);
      if (!hold_resume) check({name, " halt step"}, 32'(if0.halt), 32'(halt_exp));
      @(posedge clk); #1;
    end
    if0.start = 1'b0;
    if (hlt) halt_exp = 1'b1;
    else if (hold_resume) halt_exp = 1'b0;
    check({name, " done"},     32'(if0.done), 32'd1);
    check({name, " illegal"},  32'(if0.illegal), 32'(ill));
    check({name, " done strb"}, 32'(observed()), 32'd0);
    check({name, " halt"},     32'(if0.halt), 32'(halt_exp));
    check({name, " halt nh"},  32'(if1.halt), 32'd0);
    if0.resume = 1'b0;
    @(posedge clk); #1;
    check({name, " idle busy"}, 32'(if0.busy), 32'd0);
    check({name, " idle done"}, 32'(if0.done), 32'd0);
    if (hold_start) begin
      @(posedge clk); #1;
      check({name, " no 2nd done"}, 32'({if0.busy, if0.done}), 32'd0);
    end
  endtask

  task automatic pulse_resume();
    @(negedge clk); if0.resume = 1'b1;
    @(posedge clk); #1; if0.resume = 1'b0;
    halt_exp = 1'b0;
    check("resume clears halt", 32'(if0.halt), 32'd0);
  endtask

  initial begin
    logic [11:0] w;
    if0.start = 1'b0; if0.instruction = '0; if0.cyout = 1'b0;
    if0.accminus = 1'b0; if0.acczero = 1'b0; if0.resume = 1'b0;
    #12;
    check("reset outputs", 32'({observed(), if0.busy, if0.done, if0.illegal, if0.halt}), 32'd0);
    @(negedge clk); rst = 1'b1;

    do_op("CMA IAC", 12'o7041, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("RTL",     12'o7006, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("RAR RAL", 12'o7014, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("BSW nop", 12'o7002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("NOP",     12'o7000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("SZA z",   12'o7440, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_op("SZA nz",  12'o7440, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("SKP",     12'o7410, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("SZA CLA", 12'o7640, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("SMA SNL", 12'o7520, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("ill 1234", 12'o1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("ill 7401", 12'o7401, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("busy start", 12'o7041, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    do_op("HLT", 12'o7402, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("halt held", 32'(if0.halt), 32'd1);
    end
    pulse_resume();
    do_op("HLT+resume", 12'o7402, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    pulse_resume();

    // Reset in the middle of CLA CLL IAC: abort at once, never done.
    @(negedge clk); if0.instruction = 12'o7301; if0.start = 1'b1;
    @(posedge clk); #1; if0.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    check("mid reset outputs", 32'({observed(), if0.busy, if0.done, if0.illegal, if0.halt}), 32'd0);
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("post reset idle", 32'({if0.busy, if0.done}), 32'd0);
    end

    for (int i = 0; i < 200; i++) begin
      w = ($urandom_range(0, 3) != 0) ? {3'b111, 9'($urandom)} : 12'($urandom);
      do_op("rand", w, 1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      if (halt_exp && $urandom_range(0, 1) == 1) pulse_resume();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
